// File: rtl/frame_mii_tx.sv
// -----------------------------------------------------------------------------
// frame_mii_tx
//
// Purpose:
//   Drains whole frames from a first-word-fall-through frame FIFO and
//   serialises them onto a 4-bit MII transmit interface: 15 preamble nibbles
//   (0x5), SFD nibble (0xD), the frame bytes low nibble first, then an
//   inter-packet gap. A frame is started only when the FIFO reports at least
//   one complete frame, so a partial frame is never begun.
//
// Ports:
//   clk              MII TX clock (same as the FIFO read clock)
//   arst             asynchronous reset, active-high
//   enable           allows a new frame to start; sampled only in IDLE
//   fifo_do[7:0]     FIFO head byte (first-word-fall-through)
//   fifo_eod         head byte is the last byte of its frame
//   fifo_empty       FIFO empty flag
//   fifo_frame_exist at least one complete frame is held in the FIFO
//   fifo_re          pop strobe for the head byte (combinational)
//   txd[3:0]         MII data (registered)
//   tx_en            MII enable (registered)
//   tx_er            MII error (registered); high only in an abort cycle
//   busy             high whenever the FSM is not in IDLE
//   frame_cnt[15:0]  good frames sent, wraps at 65535
//   underrun         one-cycle pulse: FIFO ran empty inside a frame
//   oversize         one-cycle pulse: MAX_BYTES reached without an EOD
//
// Handshake: fifo_re is a pop strobe. The byte shown on fifo_do/fifo_eod is
// consumed at the rising clk edge where fifo_re is high; there is no other
// flow control on the FIFO side.
//
// Optional build macro:
//   TX_FCS_APPEND_EN  appends a CRC-32 FCS (4 bytes, LSB byte first, low
//                     nibble first) computed over the transmitted data bytes.
//                     Without it the FIFO content is sent verbatim.
//
// Timing: all MII outputs are registered, so every state decides the nibble
// shown in the following cycle. DATA is therefore entered while the SFD
// nibble is on the wire, and the first IPG cycle still shows the last nibble.
// -----------------------------------------------------------------------------
module frame_mii_tx #(
    parameter int IPG_NIBBLES = 24,
    parameter int MAX_BYTES   = 1518
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        enable,
    input  logic [7:0]  fifo_do,
    input  logic        fifo_eod,
    input  logic        fifo_empty,
    input  logic        fifo_frame_exist,
    output logic        fifo_re,
    output logic [3:0]  txd,
    output logic        tx_en,
    output logic        tx_er,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        underrun,
    output logic        oversize
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
`ifdef TX_FCS_APPEND_EN
    localparam logic [2:0] S_FCS   = 3'd3;
`endif
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_IPG   = 3'd5;

    localparam logic [10:0] MAX_B    = 11'(MAX_BYTES);
    // IPG holds IPG_NIBBLES+1 state cycles: the first one still shows the
    // final nibble of the frame through the output register.
    localparam logic [7:0]  IPG_LAST = 8'(IPG_NIBBLES);

    logic [2:0]  state_q, state_d;
    logic [3:0]  nib_q, nib_d;
    logic        phase_q, phase_d;
    logic [10:0] byte_q, byte_d;
    logic [7:0]  ipg_q, ipg_d;
    logic [3:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        underrun_q, underrun_d;
    logic        oversize_q, oversize_d;
    logic        re;

`ifdef TX_FCS_APPEND_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs_word;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                               input logic [7:0]  d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
        end
        return r;
    endfunction

    assign fcs_word = ~crc_q;
`endif

    always_comb begin
        state_d     = state_q;
        nib_d       = nib_q;
        phase_d     = phase_q;
        byte_d      = byte_q;
        ipg_d       = ipg_q;
        txd_d       = 4'h0;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        underrun_d  = 1'b0;
        oversize_d  = 1'b0;
        re          = 1'b0;
`ifdef TX_FCS_APPEND_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                nib_d   = 4'd0;
                phase_d = 1'b0;
                byte_d  = 11'd0;
                ipg_d   = 8'd0;
                if (enable && fifo_frame_exist) begin
                    state_d = S_PRE;
                    tx_en_d = 1'b1;
                    txd_d   = 4'h5;
                end
            end
            S_PRE: begin
                tx_en_d = 1'b1;
`ifdef TX_FCS_APPEND_EN
                crc_d   = 32'hFFFF_FFFF;
`endif
                // IDLE already loaded the first 0x5; 14 more, then the SFD.
                if (nib_q == 4'd14) begin
                    txd_d   = 4'hD;
                    state_d = S_DATA;
                    phase_d = 1'b0;
                end else begin
                    txd_d = 4'h5;
                    nib_d = nib_q + 4'd1;
                end
            end
            S_DATA: begin
                if (!phase_q) begin
                    if (byte_q == MAX_B || fifo_empty) begin
                        // Abort: one error nibble, then discard the rest.
                        oversize_d = (byte_q == MAX_B);
                        underrun_d = (byte_q != MAX_B);
                        tx_en_d    = 1'b1;
                        tx_er_d    = 1'b1;
                        state_d    = S_DRAIN;
                    end else begin
                        tx_en_d = 1'b1;
                        txd_d   = fifo_do[3:0];
                        phase_d = 1'b1;
                    end
                end else begin
                    tx_en_d = 1'b1;
                    txd_d   = fifo_do[7:4];
                    re      = 1'b1;
                    byte_d  = byte_q + 11'd1;
                    phase_d = 1'b0;
`ifdef TX_FCS_APPEND_EN
                    crc_d   = crc32_byte(crc_q, fifo_do);
`endif
                    if (fifo_eod) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        nib_d       = 4'd0;
                        ipg_d       = 8'd0;
`ifdef TX_FCS_APPEND_EN
                        state_d     = S_FCS;
`else
                        state_d     = S_IPG;
`endif
                    end
                end
            end
`ifdef TX_FCS_APPEND_EN
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_word[{nib_q[2:0], 2'b00} +: 4];
                if (nib_q[2:0] == 3'd7) begin
                    state_d = S_IPG;
                    ipg_d   = 8'd0;
                end else begin
                    nib_d = nib_q + 4'd1;
                end
            end
`endif
            S_DRAIN: begin
                re = ~fifo_empty;
                if (!fifo_empty && fifo_eod) begin
                    state_d = S_IPG;
                    ipg_d   = 8'd0;
                end
            end
            S_IPG: begin
                if (ipg_q == IPG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ipg_d = ipg_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            nib_q       <= 4'd0;
            phase_q     <= 1'b0;
            byte_q      <= 11'd0;
            ipg_q       <= 8'd0;
            txd_q       <= 4'h0;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            underrun_q  <= 1'b0;
            oversize_q  <= 1'b0;
`ifdef TX_FCS_APPEND_EN
            crc_q       <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            phase_q     <= phase_d;
            byte_q      <= byte_d;
            ipg_q       <= ipg_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            frame_cnt_q <= frame_cnt_d;
            underrun_q  <= underrun_d;
            oversize_q  <= oversize_d;
`ifdef TX_FCS_APPEND_EN
            crc_q       <= crc_d;
`endif
        end
    end

    // Gate the pop so the FIFO is never popped while it is being reset.
    assign fifo_re   = re & ~arst;
    assign txd       = txd_q;
    assign tx_en     = tx_en_q;
    assign tx_er     = tx_er_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_cnt = frame_cnt_q;
    assign underrun  = underrun_q;
    assign oversize  = oversize_q;

endmodule

// File: tb/tb_frame_mii_tx.sv
// -----------------------------------------------------------------------------
// tb_frame_mii_tx
//
// Bench for frame_mii_tx with default parameters (IPG_NIBBLES=24,
// MAX_BYTES=1518). A queue models the first-word-fall-through frame FIFO;
// a negedge monitor captures each tx_en burst (length, nibbles, tx_er on the
// last cycle) and the gap before it.
// -----------------------------------------------------------------------------
module tb_frame_mii_tx;

`ifdef TX_FCS_APPEND_EN
  localparam bit FCS_ON  = 1'b1;
`else
  localparam bit FCS_ON  = 1'b0;
`endif
  localparam int FCS_NIB = FCS_ON ? 8 : 0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        arst;
  logic        enable;
  logic [7:0]  fifo_do;
  logic        fifo_eod;
  logic        fifo_empty;
  logic        fifo_frame_exist;
  logic        fifo_re;
  logic [3:0]  txd;
  logic        tx_en;
  logic        tx_er;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        underrun;
  logic        oversize;

  always #5 clk = ~clk;

  frame_mii_tx dut (
    .clk              (clk),
    .arst             (arst),
    .enable           (enable),
    .fifo_do          (fifo_do),
    .fifo_eod         (fifo_eod),
    .fifo_empty       (fifo_empty),
    .fifo_frame_exist (fifo_frame_exist),
    .fifo_re          (fifo_re),
    .txd              (txd),
    .tx_en            (tx_en),
    .tx_er            (tx_er),
    .busy             (busy),
    .frame_cnt        (frame_cnt),
    .underrun         (underrun),
    .oversize         (oversize)
  );

  // ---------------- FIFO model ----------------
  logic [8:0] fifo_q[$];    // {eod, data}
  logic [7:0] frm[$];       // frame currently being built / checked
  logic       force_exist;
  logic       re_s;

  function automatic void drive_fifo();
    int eods;
    logic [8:0] h;
    eods = 0;
    foreach (fifo_q[i]) if (fifo_q[i][8]) eods++;
    h = (fifo_q.size() > 0) ? fifo_q[0] : 9'h000;
    fifo_empty       = (fifo_q.size() == 0);
    fifo_do          = h[7:0];
    fifo_eod         = h[8];
    fifo_frame_exist = force_exist || (eods > 0);
  endfunction

  always @(posedge clk) begin
    #1;
    if (re_s && fifo_q.size() > 0) fifo_q.delete(0);
    drive_fifo();
  end

  // ---------------- monitor ----------------
  int         pops, und_cnt, ovs_cnt, er_cnt, frames_seen;
  int         cur_len, last_len, gap, last_gap;
  bit         in_frame, cur_er, last_er;
  logic [3:0] cur_nib[$];
  logic [3:0] last_nib[$];

  always @(negedge clk) begin
    re_s = fifo_re;
    if (fifo_re) pops++;
    if (underrun) und_cnt++;
    if (oversize) ovs_cnt++;
    if (tx_er) er_cnt++;
    if (tx_en) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        cur_len  = 0;
        cur_nib.delete();
        last_gap = gap;
      end
      cur_len++;
      cur_nib.push_back(txd);
      cur_er = tx_er;
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        last_len = cur_len;
        last_nib = cur_nib;
        last_er  = cur_er;
        frames_seen++;
        gap = 0;
      end
      gap++;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_checks, n_fail;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Expected nibble stream for frm: preamble, SFD, data low-first, optional FCS.
  task automatic build_exp(input bit with_fcs);
    logic [31:0] crc;
    exp_q.delete();
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    crc = 32'hFFFF_FFFF;
    foreach (frm[i]) begin
      exp_q.push_back(frm[i][3:0]);
      exp_q.push_back(frm[i][7:4]);
      crc = crc_model(crc, frm[i]);
    end
    crc = ~crc;
    if (with_fcs && FCS_ON)
      for (int k = 0; k < 8; k++) exp_q.push_back(crc[4*k +: 4]);
  endtask

  task automatic cmp_nibs(input string name);
    int bad;
    bad = 0;
    if (last_nib.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[k]) if (last_nib[k] !== exp_q[k]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic make_ramp(input int len, input logic [7:0] start);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(start + 8'(i));
  endtask

  task automatic push_frm(input bit with_eod);
    foreach (frm[i]) fifo_q.push_back({1'(with_eod && (i == frm.size() - 1)), frm[i]});
    drive_fifo();
  endtask

  task automatic start_frame();
    enable = 1'b1;
    step(4);
    enable = 1'b0;   // dropping enable mid-frame must not disturb it
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (frames_seen < target && k < budget) begin step(1); k++; end
    check(name, 32'(frames_seen >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin step(1); k++; end
    check(name, 32'(busy), 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         len;
    logic [7:0] start;
    int         exp_len;   // tx_en cycles without FCS: 16 + 2*len
    int         exp_pops;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, e0, u0, o0, k;
    logic [3:0] tr[8];

    vecs[0] = '{len: 64, start: 8'h00, exp_len: 144, exp_pops: 64};
    vecs[1] = '{len: 1,  start: 8'hA5, exp_len: 18,  exp_pops: 1};
    vecs[2] = '{len: 3,  start: 8'hF0, exp_len: 22,  exp_pops: 3};
    vecs[3] = '{len: 17, start: 8'h80, exp_len: 50,  exp_pops: 17};

    n_checks = 0; n_fail = 0;
    pops = 0; und_cnt = 0; ovs_cnt = 0; er_cnt = 0; frames_seen = 0;
    cur_len = 0; last_len = 0; gap = 1000; last_gap = 0;
    in_frame = 0; cur_er = 0; last_er = 0; re_s = 0;
    arst = 1'b1; enable = 1'b0; force_exist = 1'b0;
    drive_fifo();

    // ---- reset state ----
    step(3);
    check("rst_txd", 32'(txd), 32'd0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_er", 32'(tx_er), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_oversize", 32'(oversize), 32'd0);
    check("rst_fifo_re", 32'(fifo_re), 32'd0);
    arst = 1'b0;
    step(2);

    // ---- table-driven good frames ----
    for (int i = 0; i < 4; i++) begin
      p0 = pops; f0 = frames_seen; e0 = er_cnt;
      make_ramp(vecs[i].len, vecs[i].start);
      push_frm(1'b1);
      if (i == 0) begin
        step(10);
        check("no_start_while_disabled", 32'(busy), 32'd0);
        check("no_pop_while_disabled", 32'(pops - p0), 32'd0);
      end
      start_frame();
      wait_frames(f0 + 1, 400, $sformatf("v%0d_frame_done", i));
      wait_idle(100, $sformatf("v%0d_idle", i));
      build_exp(1'b1);
      check($sformatf("v%0d_tx_en_len", i), 32'(last_len), 32'(vecs[i].exp_len + FCS_NIB));
      cmp_nibs($sformatf("v%0d_nibbles", i));
      check($sformatf("v%0d_pops", i), 32'(pops - p0), 32'(vecs[i].exp_pops));
      check($sformatf("v%0d_frame_cnt", i), 32'(frame_cnt), 32'(i + 1));
      check($sformatf("v%0d_no_tx_er", i), 32'(er_cnt - e0), 32'd0);
    end

    // ---- two back-to-back 60-byte frames ----
    p0 = pops; f0 = frames_seen;
    make_ramp(60, 8'h10); push_frm(1'b1);
    make_ramp(60, 8'h50); push_frm(1'b1);
    enable = 1'b1;
    wait_frames(f0 + 2, 700, "b2b_frames_done");
    wait_idle(100, "b2b_idle");
    enable = 1'b0;
    build_exp(1'b1);
    check("b2b_gap", 32'(last_gap), 32'd25);
    check("b2b_len", 32'(last_len), 32'(136 + FCS_NIB));
    cmp_nibs("b2b_second_nibbles");
    check("b2b_pops", 32'(pops - p0), 32'd120);
    check("b2b_frame_cnt", 32'(frame_cnt), 32'd6);

    // ---- underrun: 10 bytes, no EOD, then empty ----
    p0 = pops; f0 = frames_seen; e0 = er_cnt; u0 = und_cnt; o0 = ovs_cnt;
    force_exist = 1'b1;
    make_ramp(10, 8'h30); push_frm(1'b0);
    start_frame();
    force_exist = 1'b0;
    drive_fifo();
    wait_frames(f0 + 1, 200, "und_frame_end");
    build_exp(1'b0);
    exp_q.push_back(4'h0);
    check("und_len", 32'(last_len), 32'd37);
    cmp_nibs("und_nibbles");
    check("und_tx_er_last", 32'(last_er), 32'd1);
    check("und_tx_er_count", 32'(er_cnt - e0), 32'd1);
    check("und_pulse", 32'(und_cnt - u0), 32'd1);
    check("und_no_oversize", 32'(ovs_cnt - o0), 32'd0);
    check("und_pops", 32'(pops - p0), 32'd10);
    step(8);
    check("und_drain_waits", 32'(busy), 32'd1);
    make_ramp(3, 8'h60); push_frm(1'b1);
    wait_idle(100, "und_idle");
    check("und_drain_pops", 32'(pops - p0), 32'd13);
    check("und_fifo_empty", 32'(fifo_q.size()), 32'd0);
    check("und_frame_cnt", 32'(frame_cnt), 32'd6);

    // ---- oversize: 1600-byte frame ----
    p0 = pops; f0 = frames_seen; e0 = er_cnt; u0 = und_cnt; o0 = ovs_cnt;
    make_ramp(1600, 8'h00); push_frm(1'b1);
    start_frame();
    wait_frames(f0 + 1, 4000, "ovs_frame_end");
    frm = frm[0:1517];
    build_exp(1'b0);
    exp_q.push_back(4'h0);
    check("ovs_len", 32'(last_len), 32'd3053);
    cmp_nibs("ovs_nibbles");
    check("ovs_tx_er_last", 32'(last_er), 32'd1);
    check("ovs_pulse", 32'(ovs_cnt - o0), 32'd1);
    check("ovs_no_underrun", 32'(und_cnt - u0), 32'd0);
    wait_idle(400, "ovs_idle");
    check("ovs_pops", 32'(pops - p0), 32'd1600);
    check("ovs_frame_cnt", 32'(frame_cnt), 32'd6);

    // ---- asynchronous reset during DATA byte 20 ----
    p0 = pops;
    make_ramp(40, 8'h20); push_frm(1'b1);
    make_ramp(8, 8'hC0); push_frm(1'b1);
    enable = 1'b1;
    k = 0;
    while ((pops - p0) < 20 && k < 300) begin step(1); k++; end
    check("rst_reach_byte20", 32'((pops - p0) >= 20), 32'd1);
    enable = 1'b0;
    arst = 1'b1;
    #1;
    check("midrst_tx_en", 32'(tx_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fifo_re", 32'(fifo_re), 32'd0);
    fifo_q.delete();          // FIFO shares the reset
    drive_fifo();
    step(2);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    arst = 1'b0;
    step(1);
    f0 = frames_seen;
    push_frm(1'b1);           // frm still holds the 8-byte frame
    start_frame();
    wait_frames(f0 + 1, 200, "postrst_frame_done");
    wait_idle(100, "postrst_idle");
    build_exp(1'b1);
    check("postrst_len", 32'(last_len), 32'(32 + FCS_NIB));
    cmp_nibs("postrst_nibbles");
    check("postrst_frame_cnt", 32'(frame_cnt), 32'd1);

`ifdef TX_FCS_APPEND_EN
    // ---- FCS of "123456789" is 0xCBF43926 ----
    tr = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    f0 = frames_seen;
    make_ramp(9, 8'h31); push_frm(1'b1);
    start_frame();
    wait_frames(f0 + 1, 200, "fcs_frame_done");
    wait_idle(100, "fcs_idle");
    check("fcs_len", 32'(last_len), 32'd42);
    k = 0;
    if (last_nib.size() >= 8)
      for (int j = 0; j < 8; j++) if (last_nib[last_nib.size() - 8 + j] !== tr[j]) k++;
    else k = 8;
    check("fcs_trailer", 32'(k), 32'd0);
`else
    tr = '{default: 4'h0};
    if (tr[0] != 4'h0) $display("unused");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_mii_tx.md
Name: frame_mii_tx

Overview:
Drains whole frames from the FRAME_FIFO read port and serialises them onto a 4-bit MII transmit interface. For each frame it sends preamble/SFD, then the frame bytes low nibble first, then an inter-packet gap. It starts a frame only when the FIFO reports a complete frame (frame_exist), so it never starts on a partial frame. It sits in the read-clock domain of the FIFO, directly downstream of it.

Parameters:
IPG_NIBBLES, 24, idle nibble-times (tx_en=0) held after every frame; legal range 1..255
MAX_BYTES, 1518, data bytes allowed before an EOD must be seen; legal range 1..2047

Ports:
clk  input  1  MII TX clock; same clock as the FIFO read clock
arst  input  1  asynchronous reset, active-high
enable  input  1  allows a new frame to start; sampled only in IDLE
fifo_do  input  8  FIFO head byte; first-word-fall-through
fifo_eod  input  1  head byte is the last byte of its frame
fifo_empty  input  1  FIFO empty flag
fifo_frame_exist  input  1  at least one complete frame is in the FIFO
fifo_re  output  1  pop the head byte; combinational
txd  output  4  MII data, registered
tx_en  output  1  MII enable, registered
tx_er  output  1  MII error, registered
busy  output  1  high whenever state != IDLE
frame_cnt  output  16  count of good frames sent; wraps at 65535
underrun  output  1  one-cycle pulse: FIFO went empty mid-frame
oversize  output  1  one-cycle pulse: MAX_BYTES reached without an EOD

Behaviour:
- Reset: arst is asynchronous and active-high.
  - Outputs: txd=0, tx_en=0, tx_er=0, busy=0, frame_cnt=0, underrun=0, oversize=0.
  - Internal state: state=IDLE; nibble, byte and IPG counters=0.
  - fifo_re=0 while arst is high.
  - Mid-frame reset drops tx_en in the same instant. arst shares its source with the FIFO reset, so no frame residue survives reset.
- States: IDLE, PRE, DATA, FCS (only when the optional feature is compiled in), DRAIN, IPG.
- IDLE → PRE when enable & fifo_frame_exist in cycle T. The first preamble nibble appears on txd in cycle T+1.
- PRE: 16 cycles with tx_en=1. txd=0x5 for 15 cycles, then 0xD. Then → DATA.
- DATA, per byte (2 cycles):
  - Phase 0: txd<=fifo_do[3:0].
  - Phase 1: txd<=fifo_do[7:4], and fifo_re=1 for exactly this cycle.
  - The byte counter increments on each pop.
  - EOD popped in phase 1 → FCS if compiled in, else IPG. frame_cnt increments by 1 on that edge.
  - fifo_empty=1 at phase 0 → underrun abort.
  - Byte counter == MAX_BYTES at phase 0 with no EOD yet popped → oversize abort.
- Abort:
  - Next cycle: tx_en=1, tx_er=1, txd=0 for exactly 1 cycle, and the matching pulse fires.
  - Then → DRAIN with tx_en=0.
  - frame_cnt does not increment.
- DRAIN:
  - fifo_re = ~fifo_empty each cycle; nothing is transmitted.
  - → IPG in the cycle an EOD byte is popped.
  - On an empty FIFO it waits indefinitely.
- IPG: tx_en=0, txd=0 for IPG_NIBBLES cycles, then → IDLE.
  - Between back-to-back frames tx_en is low for exactly IPG_NIBBLES+1 cycles (the +1 is the IDLE decision cycle).
- enable deasserted mid-frame has no effect on the frame in progress.
- fifo_frame_exist may lag one cycle after the EOD pop; the IPG state covers this lag.
- tx_er is high only in the abort cycle.

Optional Feature:
TX_FCS_APPEND_EN
- Defined:
  - CRC-32 is computed over every transmitted data byte: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - The CRC is reset in PRE.
  - After EOD, state FCS sends 4 bytes LSB byte first, low nibble first: 8 cycles, tx_en=1. Then → IPG.
  - An aborted frame sends no FCS.
- Undefined: no FCS logic and no FCS state. The FIFO content is sent verbatim and is expected to already contain the FCS.
- No padding in either mode.

Test Plan:
1. 64-byte frame 0x00..0x3F, EOD on the last byte → tx_en high for 144 cycles (160 with TX_FCS_APPEND_EN). txd sequence: 5×15, D, 0,0,1,0,2,0… ending F,3. fifo_re pulses exactly 64 times; frame_cnt=1.
2. Two 60-byte frames preloaded → tx_en low for exactly 25 cycles between frames (IPG_NIBBLES=24); frame_cnt=2.
3. frame_exist forced high, 10 bytes without EOD, then empty → cycle after byte 10: tx_en=1, tx_er=1 for 1 cycle, underrun pulse. Then DRAIN; write 3 more bytes with EOD → 3 pops, then IPG. frame_cnt unchanged.
4. 1600-byte frame with MAX_BYTES=1518 → tx_er after 1518 bytes plus oversize pulse. The remaining 82 bytes are popped with tx_en=0; frame_cnt unchanged.
5. arst pulsed during DATA byte 20 → tx_en=0 and busy=0 immediately. After release, the next preloaded frame transmits normally from its preamble.
6. With TX_FCS_APPEND_EN, frame ASCII "123456789" → trailer nibbles after the data are 6,2,9,3,4,F,B,C (CRC 0xCBF43926).
